// File: rtl/mem_stack_unit_pkg.sv
// Shared encodings for the memory/stack stage: control-bundle field positions,
// address/data select codes, pop half codes and the return assembler states.
package mem_stack_unit_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 11;
    localparam int PC_W_DEF   = 32;
    localparam int FLAG_W     = 3;

    // mem_ctl = {memRead, memWrite, memAddress[1:0], memData[2:0]}
    localparam int MC_READ    = 6;
    localparam int MC_WRITE   = 5;
    localparam int MC_ADDR_HI = 4;
    localparam int MC_ADDR_LO = 3;
    localparam int MC_DATA_HI = 2;
    localparam int MC_DATA_LO = 0;

    // wb_ctl = {sp_wr, flags_wb, wb_sel, pop_l_h[1:0], regwrite}
    localparam int WB_SP_WR    = 5;
    localparam int WB_FLAGS    = 4;
    localparam int WB_SEL      = 3;
    localparam int WB_POP_HI   = 2;
    localparam int WB_POP_LO   = 1;
    localparam int WB_REGWRITE = 0;

    localparam logic [1:0] ADDR_ALU   = 2'b00;
    localparam logic [1:0] ADDR_STORE = 2'b01;
    localparam logic [1:0] ADDR_POP   = 2'b10;
    localparam logic [1:0] ADDR_PUSH  = 2'b11;

    localparam logic [2:0] DATA_REG     = 3'b000;
    localparam logic [2:0] DATA_REG_ALT = 3'b001;
    localparam logic [2:0] DATA_FLAGS   = 3'b010;
    localparam logic [2:0] DATA_PC_LO   = 3'b011;
    localparam logic [2:0] DATA_PC_HI   = 3'b100;
    localparam logic [2:0] DATA_PC1_LO  = 3'b101;
    localparam logic [2:0] DATA_PC1_HI  = 3'b110;
    localparam logic [2:0] DATA_ZERO    = 3'b111;

    localparam logic [1:0] POP_NONE = 2'b00;
    localparam logic [1:0] POP_LOW  = 2'b10;
    localparam logic [1:0] POP_HIGH = 2'b11;

    typedef enum logic [0:0] {
        ASM_IDLE     = 1'b0,
        ASM_HAVE_LOW = 1'b1
    } asm_state_t;

endpackage

// File: rtl/mem_stack_unit_ret_pc_assembler.sv
// Rebuilds a return PC from two popped words: low half first, then high half.
// Pulses are combinational in the response cycle so the PC is ready one cycle after the second pop.
module mem_stack_unit_ret_pc_assembler
    import mem_stack_unit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PC_W   = PC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              pop_valid,
    input  logic [1:0]        pop_code,
    input  logic [DATA_W-1:0] rdata,
    output logic [PC_W-1:0]   ret_pc,
    output logic              ret_pc_valid,
    output logic              err
);

    asm_state_t        state;
    asm_state_t        next_state;
    logic [DATA_W-1:0] low_half;
    logic              fire_low;
    logic              fire_high;

    assign fire_low  = pop_valid & ~stall & (pop_code == POP_LOW);
    assign fire_high = pop_valid & ~stall & (pop_code == POP_HIGH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ASM_IDLE;
            low_half <= '0;
        end else begin
            state <= next_state;
            if (fire_low) begin
                low_half <= rdata;
            end
        end
    end

    // A repeated low pop while waiting simply replaces the stored half.
    always_comb begin
        next_state = state;
        case (state)
            ASM_IDLE:     if (fire_low)  next_state = ASM_HAVE_LOW;
            ASM_HAVE_LOW: if (fire_high) next_state = ASM_IDLE;
            default:      next_state = ASM_IDLE;
        endcase
    end

    always_comb begin
        ret_pc       = PC_W'({rdata, low_half});
        ret_pc_valid = fire_high & (state == ASM_HAVE_LOW);
        err          = fire_high & (state == ASM_IDLE);
    end

endmodule

// File: rtl/mem_stack_unit.sv
// Memory stage: owns SP, drives the data RAM for loads/stores/push/pop and
// turns RAM responses into writeback data, restored flags and return PCs.
module mem_stack_unit
    import mem_stack_unit_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                PC_W     = PC_W_DEF,
    parameter logic [ADDR_W-1:0] SP_RESET = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [6:0]        mem_ctl,
    input  logic [5:0]        wb_ctl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] reg_data,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic [PC_W-1:0]   pc_cur,
    input  logic [PC_W-1:0]   pc_plus1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] sp,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_regwrite,
    output logic              ret_pc_valid,
    output logic [PC_W-1:0]   ret_pc,
    output logic              flags_valid,
    output logic [FLAG_W-1:0] flags_restore,
    output logic              proto_err
);

    logic              rd_req;
    logic              wr_req;
    logic              bad_req;
    logic [1:0]        addr_sel;
    logic [2:0]        data_sel;

    logic              resp_live;
    logic              resp_read;
    logic              resp_flags;
    logic              resp_sel;
    logic [1:0]        resp_pop;
    logic              resp_regwrite;
    logic [DATA_W-1:0] resp_alu;
    logic              asm_err;

    assign rd_req   = mem_ctl[MC_READ];
    assign wr_req   = mem_ctl[MC_WRITE];
    assign bad_req  = rd_req & wr_req;
    assign addr_sel = mem_ctl[MC_ADDR_HI:MC_ADDR_LO];
    assign data_sel = mem_ctl[MC_DATA_HI:MC_DATA_LO];

    assign mem_re = rd_req & ~wr_req & ~stall;
    assign mem_we = wr_req & ~rd_req & ~stall;

    always_comb begin
        mem_addr = alu_result[ADDR_W-1:0];
        case (addr_sel)
            ADDR_ALU:   mem_addr = alu_result[ADDR_W-1:0];
            ADDR_STORE: mem_addr = alu_result[ADDR_W-1:0];
            ADDR_POP:   mem_addr = sp + ADDR_W'(1);
            ADDR_PUSH:  mem_addr = sp;
            default:    mem_addr = alu_result[ADDR_W-1:0];
        endcase
    end

    always_comb begin
        mem_wdata = '0;
        case (data_sel)
            DATA_REG:     mem_wdata = reg_data;
            DATA_REG_ALT: mem_wdata = reg_data;
            DATA_FLAGS:   mem_wdata = DATA_W'(flags_in);
            DATA_PC_LO:   mem_wdata = pc_cur[DATA_W-1:0];
            DATA_PC_HI:   mem_wdata = pc_cur[PC_W-1:DATA_W];
            DATA_PC1_LO:  mem_wdata = pc_plus1[DATA_W-1:0];
            DATA_PC1_HI:  mem_wdata = pc_plus1[PC_W-1:DATA_W];
            DATA_ZERO:    mem_wdata = '0;
            default:      mem_wdata = '0;
        endcase
    end

    // SP wraps naturally in ADDR_W bits, so 0 <-> all-ones needs no special case.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= SP_RESET;
        end else if (mem_we && addr_sel == ADDR_PUSH && wb_ctl[WB_SP_WR]) begin
            sp <= sp - ADDR_W'(1);
        end else if (mem_re && addr_sel == ADDR_POP) begin
            sp <= sp + ADDR_W'(1);
        end
    end

    // Request-to-response stage: holds through a stall so a pending read is consumed later.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_live     <= 1'b0;
            resp_read     <= 1'b0;
            resp_flags    <= 1'b0;
            resp_sel      <= 1'b0;
            resp_pop      <= POP_NONE;
            resp_regwrite <= 1'b0;
            resp_alu      <= '0;
        end else if (!stall) begin
            resp_live     <= ~bad_req;
            resp_read     <= rd_req & ~wr_req;
            resp_flags    <= wb_ctl[WB_FLAGS];
            resp_sel      <= wb_ctl[WB_SEL];
            resp_pop      <= wb_ctl[WB_POP_HI:WB_POP_LO];
            resp_regwrite <= wb_ctl[WB_REGWRITE];
            resp_alu      <= alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_data     <= '0;
            wb_regwrite <= 1'b0;
        end else if (!stall) begin
            wb_data     <= resp_sel ? mem_rdata : resp_alu;
            wb_regwrite <= resp_live & resp_regwrite & (resp_pop == POP_NONE) & ~resp_flags;
        end
    end

    assign flags_valid   = ~stall & resp_read & resp_flags;
    assign flags_restore = mem_rdata[FLAG_W-1:0];
    assign proto_err     = (bad_req & ~stall) | asm_err;

    mem_stack_unit_ret_pc_assembler #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W)
    ) u_ret_pc_assembler (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .pop_valid    (resp_read),
        .pop_code     (resp_pop),
        .rdata        (mem_rdata),
        .ret_pc       (ret_pc),
        .ret_pc_valid (ret_pc_valid),
        .err          (asm_err)
    );

endmodule

// File: tb/tb_mem_stack_unit.sv
// Directed bench for mem_stack_unit with a synchronous RAM model and
// hand-computed expectations for CALL/RET, flags restore, stalls and SP wrap.
module tb_mem_stack_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [6:0]  mem_ctl;
    logic [5:0]  wb_ctl;
    logic [15:0] alu_result;
    logic [15:0] reg_data;
    logic [2:0]  flags_in;
    logic [31:0] pc_cur;
    logic [31:0] pc_plus1;
    logic [10:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata;
    logic [10:0] sp;
    logic [15:0] wb_data;
    logic        wb_regwrite;
    logic        ret_pc_valid;
    logic [31:0] ret_pc;
    logic        flags_valid;
    logic [2:0]  flags_restore;
    logic        proto_err;

    logic [15:0] ram [0:2047];
    int          compared;
    int          mismatched;

    mem_stack_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .mem_ctl       (mem_ctl),
        .wb_ctl        (wb_ctl),
        .alu_result    (alu_result),
        .reg_data      (reg_data),
        .flags_in      (flags_in),
        .pc_cur        (pc_cur),
        .pc_plus1      (pc_plus1),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_re        (mem_re),
        .mem_rdata     (mem_rdata),
        .sp            (sp),
        .wb_data       (wb_data),
        .wb_regwrite   (wb_regwrite),
        .ret_pc_valid  (ret_pc_valid),
        .ret_pc        (ret_pc),
        .flags_valid   (flags_valid),
        .flags_restore (flags_restore),
        .proto_err     (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: read data appears after the edge and holds until the next read.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    task automatic apply_stimulus(input logic [6:0] mc, input logic [5:0] wb);
        mem_ctl = mc;
        wb_ctl  = wb;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        for (int i = 0; i < 2048; i++) ram[i] = 16'h0000;
        mem_rdata  = 16'h0000;
        rst        = 1'b1;
        stall      = 1'b0;
        mem_ctl    = 7'b0;
        wb_ctl     = 6'b0;
        alu_result = 16'h0000;
        reg_data   = 16'h0000;
        flags_in   = 3'b000;
        pc_cur     = 32'h0;
        pc_plus1   = 32'h00012345;
        tick();
        tick();

        $display("[TB] reset state");
        check_output("rst_sp", 32'(sp), 32'h7FF);
        check_output("rst_we", 32'(mem_we), 32'h0);
        check_output("rst_re", 32'(mem_re), 32'h0);
        check_output("rst_retv", 32'(ret_pc_valid), 32'h0);
        check_output("rst_flagv", 32'(flags_valid), 32'h0);
        check_output("rst_err", 32'(proto_err), 32'h0);
        check_output("rst_regwr", 32'(wb_regwrite), 32'h0);
        rst = 1'b0;

        $display("[TB] CALL pushes high then low return half");
        apply_stimulus(7'b0111110, 6'b100000);
        check_output("call_hi_we", 32'(mem_we), 32'h1);
        check_output("call_hi_addr", 32'(mem_addr), 32'h7FF);
        check_output("call_hi_data", 32'(mem_wdata), 32'h0001);
        tick();
        check_output("call_hi_sp", 32'(sp), 32'h7FE);
        apply_stimulus(7'b0111101, 6'b100000);
        check_output("call_lo_addr", 32'(mem_addr), 32'h7FE);
        check_output("call_lo_data", 32'(mem_wdata), 32'h2345);
        tick();
        apply_stimulus(7'b0, 6'b0);
        check_output("call_sp", 32'(sp), 32'h7FD);
        check_output("ram_7ff", 32'(ram[11'h7FF]), 32'h0001);
        check_output("ram_7fe", 32'(ram[11'h7FE]), 32'h2345);

        $display("[TB] RET pops low then high");
        apply_stimulus(7'b1010000, 6'b101101);
        check_output("ret_lo_re", 32'(mem_re), 32'h1);
        check_output("ret_lo_addr", 32'(mem_addr), 32'h7FE);
        tick();
        apply_stimulus(7'b1010000, 6'b101111);
        check_output("ret_hi_addr", 32'(mem_addr), 32'h7FF);
        check_output("ret_early_valid", 32'(ret_pc_valid), 32'h0);
        tick();
        apply_stimulus(7'b0, 6'b0);
        check_output("ret_valid", 32'(ret_pc_valid), 32'h1);
        check_output("ret_pc", ret_pc, 32'h00012345);
        check_output("ret_sp", 32'(sp), 32'h7FF);
        check_output("ret_err", 32'(proto_err), 32'h0);
        tick();
        check_output("ret_valid_drop", 32'(ret_pc_valid), 32'h0);
        check_output("ret_regwr", 32'(wb_regwrite), 32'h0);

        $display("[TB] flags push and restore");
        flags_in = 3'b101;
        apply_stimulus(7'b0111010, 6'b100000);
        check_output("flag_push_data", 32'(mem_wdata), 32'h0005);
        tick();
        apply_stimulus(7'b1010000, 6'b111000);
        check_output("flag_pop_addr", 32'(mem_addr), 32'h7FF);
        tick();
        apply_stimulus(7'b0, 6'b0);
        check_output("flag_valid", 32'(flags_valid), 32'h1);
        check_output("flag_value", 32'(flags_restore), 32'h5);
        check_output("flag_sp", 32'(sp), 32'h7FF);
        tick();
        check_output("flag_valid_drop", 32'(flags_valid), 32'h0);
        check_output("flag_regwr", 32'(wb_regwrite), 32'h0);

        $display("[TB] RET with a two-cycle stall between pops");
        apply_stimulus(7'b0111110, 6'b100000);
        tick();
        apply_stimulus(7'b0111101, 6'b100000);
        tick();
        apply_stimulus(7'b1010000, 6'b101101);
        tick();
        stall = 1'b1;
        apply_stimulus(7'b1010000, 6'b101111);
        check_output("stall_re", 32'(mem_re), 32'h0);
        check_output("stall_we", 32'(mem_we), 32'h0);
        check_output("stall_retv", 32'(ret_pc_valid), 32'h0);
        tick();
        check_output("stall_sp1", 32'(sp), 32'h7FE);
        tick();
        check_output("stall_sp2", 32'(sp), 32'h7FE);
        check_output("stall_re2", 32'(mem_re), 32'h0);
        stall = 1'b0;
        #1;
        check_output("unstall_re", 32'(mem_re), 32'h1);
        check_output("unstall_addr", 32'(mem_addr), 32'h7FF);
        tick();
        apply_stimulus(7'b0, 6'b0);
        check_output("stall_ret_valid", 32'(ret_pc_valid), 32'h1);
        check_output("stall_ret_pc", ret_pc, 32'h00012345);
        tick();
        check_output("stall_ret_drop", 32'(ret_pc_valid), 32'h0);

        $display("[TB] SP wrap in both directions");
        apply_stimulus(7'b1010000, 6'b100000);
        check_output("wrap_pop_addr", 32'(mem_addr), 32'h000);
        tick();
        check_output("wrap_pop_sp", 32'(sp), 32'h000);
        reg_data = 16'hBEEF;
        apply_stimulus(7'b0111000, 6'b100000);
        check_output("wrap_push_addr", 32'(mem_addr), 32'h000);
        check_output("wrap_push_data", 32'(mem_wdata), 32'hBEEF);
        tick();
        check_output("wrap_push_sp", 32'(sp), 32'h7FF);

        $display("[TB] protocol errors");
        apply_stimulus(7'b1010000, 6'b101111);
        tick();
        apply_stimulus(7'b0, 6'b0);
        check_output("idle_hi_err", 32'(proto_err), 32'h1);
        check_output("idle_hi_valid", 32'(ret_pc_valid), 32'h0);
        tick();
        check_output("idle_hi_err_drop", 32'(proto_err), 32'h0);
        apply_stimulus(7'b1111000, 6'b100000);
        check_output("rw_err", 32'(proto_err), 32'h1);
        check_output("rw_we", 32'(mem_we), 32'h0);
        check_output("rw_re", 32'(mem_re), 32'h0);
        tick();
        check_output("rw_sp", 32'(sp), 32'h000);

        $display("[TB] load and ALU writeback");
        alu_result = 16'h07FE;
        apply_stimulus(7'b1000000, 6'b001001);
        tick();
        apply_stimulus(7'b0, 6'b0);
        tick();
        check_output("ldd_data", 32'(wb_data), 32'h2345);
        check_output("ldd_regwr", 32'(wb_regwrite), 32'h1);
        alu_result = 16'h1234;
        apply_stimulus(7'b0, 6'b000001);
        tick();
        apply_stimulus(7'b0, 6'b0);
        tick();
        check_output("alu_data", 32'(wb_data), 32'h1234);
        check_output("alu_regwr", 32'(wb_regwrite), 32'h1);

        $display("[TB] reset discards a partial return PC");
        apply_stimulus(7'b1010000, 6'b101101);
        tick();
        rst = 1'b1;
        apply_stimulus(7'b0, 6'b0);
        tick();
        rst = 1'b0;
        check_output("mid_rst_sp", 32'(sp), 32'h7FF);
        apply_stimulus(7'b1010000, 6'b101111);
        tick();
        apply_stimulus(7'b0, 6'b0);
        check_output("mid_rst_valid", 32'(ret_pc_valid), 32'h0);
        check_output("mid_rst_err", 32'(proto_err), 32'h1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
